// File: rtl/count_monitor_if.sv
// Signal bundle between the ripple-counter monitor and its user logic.
// master drives the raw count and controls; slave is count_monitor.
interface count_monitor_if #(
  parameter int N = 4
);
  logic [N-1:0] count_in;
  logic [N-1:0] cmp_val;
  logic         cmp_load;
  logic         wrap_clr;
  logic [N-1:0] count_q;
  logic         valid;
  logic         match_pulse;
  logic         wrap_pulse;
  logic [7:0]   wrap_cnt;

  modport master (
    output count_in, cmp_val, cmp_load, wrap_clr,
    input  count_q, valid, match_pulse, wrap_pulse, wrap_cnt
  );

  modport slave (
    input  count_in, cmp_val, cmp_load, wrap_clr,
    output count_q, valid, match_pulse, wrap_pulse, wrap_cnt
  );
endinterface

// File: rtl/count_monitor.sv
// Synchronizes and debounces an asynchronous ripple-counter value into the clk domain.
// Optional wrap event counter enabled by defining COUNT_MONITOR_WRAP_CNT_EN.
module count_monitor #(
  parameter int N      = 4,
  parameter int STABLE = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  count_monitor_if.slave  mon
);

  localparam int            SW       = 4;
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t        state_reg, state_next;
  logic [N-1:0]  s2_bus;
  logic [N-1:0]  cand_reg;
  logic [N-1:0]  count_reg;
  logic [N-1:0]  cmp_reg;
  logic [SW-1:0] stab_reg;
  logic [1:0]    fill_reg;
  logic          cand_valid_reg;
  logic          valid_reg;
  logic          match_reg;
  logic          wrap_reg;
  logic          accept;
  logic          do_update;
  logic          wrap_event;
  logic          match_event;

  // Two-flop synchronizer per bit; the only reader of count_in.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_sync
      logic s1_bit_reg;
      logic s2_bit_reg;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          s1_bit_reg <= 1'b0;
          s2_bit_reg <= 1'b0;
        end else begin
          s1_bit_reg <= mon.count_in[gi];
          s2_bit_reg <= s1_bit_reg;
        end
      end
      assign s2_bus[gi] = s2_bit_reg;
    end
  endgenerate

  // s2 carries a genuine sample only from the second edge after reset, and cand
  // starts empty, so a fresh run always needs the full STABLE+2 edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fill_reg       <= 2'b00;
      cand_reg       <= '0;
      cand_valid_reg <= 1'b0;
      stab_reg       <= '0;
    end else begin
      fill_reg <= {fill_reg[0], 1'b1};
      if (fill_reg[1]) begin
        if (!cand_valid_reg || (s2_bus != cand_reg)) begin
          cand_reg       <= s2_bus;
          cand_valid_reg <= 1'b1;
          stab_reg       <= '0;
        end else if (stab_reg < STAB_MAX) begin
          stab_reg <= stab_reg + 4'd1;
        end
      end
    end
  end

  assign accept = fill_reg[1] && cand_valid_reg && (s2_bus == cand_reg) &&
                  (stab_reg >= STAB_MAX);

  always_comb begin
    state_next = state_reg;
    do_update  = 1'b0;
    case (state_reg)
      INIT: begin
        if (accept) begin
          do_update  = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (accept && (cand_reg != count_reg)) begin
          do_update = 1'b1;
        end
      end
      default: state_next = INIT;
    endcase
  end

  // cmp_reg is read before its own update, so a same-edge load compares against the old value.
  assign match_event = do_update && (cand_reg == cmp_reg);
  assign wrap_event  = do_update && (state_reg == RUN) && (cand_reg < count_reg);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= INIT;
      count_reg <= '0;
      cmp_reg   <= '0;
      valid_reg <= 1'b0;
      match_reg <= 1'b0;
      wrap_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      match_reg <= match_event;
      wrap_reg  <= wrap_event;
      if (do_update) begin
        count_reg <= cand_reg;
        valid_reg <= 1'b1;
      end
      if (mon.cmp_load) begin
        cmp_reg <= mon.cmp_val;
      end
    end
  end

`ifdef COUNT_MONITOR_WRAP_CNT_EN
  logic [7:0] wrap_cnt_reg;

  // Clear wins over a coincident wrap event.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrap_cnt_reg <= 8'd0;
    end else if (mon.wrap_clr) begin
      wrap_cnt_reg <= 8'd0;
    end else if (wrap_event && (wrap_cnt_reg != 8'hFF)) begin
      wrap_cnt_reg <= wrap_cnt_reg + 8'd1;
    end
  end

  assign mon.wrap_cnt = wrap_cnt_reg;
`else
  logic unused_wrap_clr;
  assign unused_wrap_clr = mon.wrap_clr;
  assign mon.wrap_cnt    = 8'd0;
`endif

  assign mon.count_q     = count_reg;
  assign mon.valid       = valid_reg;
  assign mon.match_pulse = match_reg;
  assign mon.wrap_pulse  = wrap_reg;

endmodule

// File: tb/tb_count_monitor.sv
// Bench for count_monitor: directed scenarios with literal expectations plus
// random hold lengths, all compared every cycle against a sample-window model.
module tb_count_monitor;

  localparam int N      = 4;
  localparam int STABLE = 2;
`ifdef COUNT_MONITOR_WRAP_CNT_EN
  localparam bit WC_EN = 1'b1;
`else
  localparam bit WC_EN = 1'b0;
`endif

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  count_monitor_if #(.N(N)) bus ();

  count_monitor #(.N(N), .STABLE(STABLE)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .mon     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a value is accepted at edge e when the STABLE+1 raw samples taken at
  // edges e-2-STABLE .. e-2 (counted from reset release) are all equal.
  int hist[$];
  int m_count = 0;
  int m_cmp   = 0;
  int m_wc    = 0;
  bit m_valid = 1'b0;
  bit m_match = 1'b0;
  bit m_wrap  = 1'b0;

  task automatic model_reset();
    hist.delete();
    m_count = 0;
    m_cmp   = 0;
    m_wc    = 0;
    m_valid = 1'b0;
    m_match = 1'b0;
    m_wrap  = 1'b0;
  endtask

  task automatic model_edge();
    int e;
    int v;
    bit acc;
    hist.push_back(int'(bus.count_in));
    e       = hist.size() - 1;
    m_match = 1'b0;
    m_wrap  = 1'b0;
    acc     = 1'b0;
    v       = 0;
    if (e - 2 - STABLE >= 0) begin
      acc = 1'b1;
      v   = hist[e-2];
      for (int k = e - 2 - STABLE; k < e - 2; k++) begin
        if (hist[k] != v) acc = 1'b0;
      end
    end
    if (acc) begin
      if (!m_valid) begin
        m_valid = 1'b1;
        m_match = (v == m_cmp);
        m_count = v;
      end else if (v != m_count) begin
        m_wrap  = (v < m_count);
        m_match = (v == m_cmp);
        m_count = v;
      end
    end
    if (bus.wrap_clr) m_wc = 0;
    else if (m_wrap && m_wc < 255) m_wc++;
    if (bus.cmp_load) m_cmp = int'(bus.cmp_val);
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else model_edge();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("count_q", 32'(bus.count_q), m_count);
      chk("valid", 32'(bus.valid), 32'(m_valid));
      chk("match_pulse", 32'(bus.match_pulse), 32'(m_match));
      chk("wrap_pulse", 32'(bus.wrap_pulse), 32'(m_wrap));
      chk("wrap_cnt", 32'(bus.wrap_cnt), WC_EN ? m_wc : 0);
    end
  end

  task automatic step(input int v, input bit quiet);
    bus.count_in = N'(v - 1) & N'(v);
    #1;
    bus.count_in = N'(v);
    repeat (STABLE + 3) @(negedge clk);
    if (!quiet)
      $display("step count_in=%0d count_q=%0d valid=%0b match=%0b wrap=%0b wrap_cnt=%0d",
               v, bus.count_q, bus.valid, bus.match_pulse, bus.wrap_pulse, bus.wrap_cnt);
  endtask

  task automatic load_cmp(input int v);
    bus.cmp_load = 1'b1;
    bus.cmp_val  = N'(v);
    @(negedge clk);
    bus.cmp_load = 1'b0;
    $display("load cmp_val=%0d", v);
  endtask

  initial begin
    int v;
    int hold;
    bus.count_in = '0;
    bus.cmp_val  = '0;
    bus.cmp_load = 1'b0;
    bus.wrap_clr = 1'b0;

    // Reset state, then first acceptance of 0 after release.
    repeat (2) @(negedge clk);
    chk("reset count_q", 32'(bus.count_q), 0);
    chk("reset valid", 32'(bus.valid), 0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("init valid early", 32'(bus.valid), 0);
    @(negedge clk);
    chk("init valid", 32'(bus.valid), 1);
    chk("init match", 32'(bus.match_pulse), 1);
    chk("init wrap", 32'(bus.wrap_pulse), 0);
    @(negedge clk);
    chk("init match gone", 32'(bus.match_pulse), 0);
    $display("release count_q=%0d valid=%0b", bus.count_q, bus.valid);

    // Ripple counter walk 1..15 then wrap to 0.
    for (int i = 1; i < 16; i++) begin
      step(i, 1'b0);
      chk("walk count_q", 32'(bus.count_q), i);
      chk("walk wrap", 32'(bus.wrap_pulse), 0);
    end
    step(0, 1'b0);
    chk("wrap pulse", 32'(bus.wrap_pulse), 1);
    chk("wrap match", 32'(bus.match_pulse), 1);
    chk("wrap count", 32'(bus.wrap_cnt), WC_EN ? 1 : 0);

    // Compare value matching.
    load_cmp(9);
    step(9, 1'b0);
    chk("cmp match", 32'(bus.match_pulse), 1);
    @(negedge clk);
    chk("cmp single", 32'(bus.match_pulse), 0);
    load_cmp(2);
    step(5, 1'b0);
    bus.count_in = 4'd9;
    repeat (STABLE + 2) @(negedge clk);
    bus.cmp_load = 1'b1;
    bus.cmp_val  = 4'd9;
    @(negedge clk);
    bus.cmp_load = 1'b0;
    chk("same-edge load count_q", 32'(bus.count_q), 9);
    chk("same-edge load match", 32'(bus.match_pulse), 0);
    $display("same-edge load count_q=%0d match=%0b", bus.count_q, bus.match_pulse);
    step(4, 1'b0);
    step(9, 1'b0);
    chk("loaded cmp match", 32'(bus.match_pulse), 1);

    // Short glitch must be rejected.
    step(5, 1'b0);
    bus.count_in = 4'd6;
    repeat (2) @(negedge clk);
    bus.count_in = 4'd5;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("glitch count_q", 32'(bus.count_q), 5);
      chk("glitch wrap", 32'(bus.wrap_pulse), 0);
    end
    $display("glitch 5->6->5 count_q=%0d", bus.count_q);

    // Saturation, then clear coincident with a wrap.
    for (int i = 0; i < 256; i++) begin
      step(15, 1'b1);
      step(0, 1'b1);
    end
    chk("saturate", 32'(bus.wrap_cnt), WC_EN ? 255 : 0);
    $display("after 256 wraps wrap_cnt=%0d", bus.wrap_cnt);
    step(15, 1'b0);
    bus.count_in = '0;
    repeat (STABLE + 2) @(negedge clk);
    bus.wrap_clr = 1'b1;
    @(negedge clk);
    bus.wrap_clr = 1'b0;
    chk("clr+wrap pulse", 32'(bus.wrap_pulse), 1);
    chk("clr+wrap cnt", 32'(bus.wrap_cnt), 0);
    step(15, 1'b0);
    step(0, 1'b0);
    chk("post clr cnt", 32'(bus.wrap_cnt), WC_EN ? 1 : 0);

    // Short asynchronous reset mid-count.
    step(7, 1'b0);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("async count_q", 32'(bus.count_q), 0);
    chk("async valid", 32'(bus.valid), 0);
    chk("async wrap_cnt", 32'(bus.wrap_cnt), 0);
    #2 reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("reacq valid early", 32'(bus.valid), 0);
    @(negedge clk);
    chk("reacq valid", 32'(bus.valid), 1);
    chk("reacq count_q", 32'(bus.count_q), 7);
    $display("reset reacquire count_q=%0d valid=%0b", bus.count_q, bus.valid);

    // Random holds, some too short to be accepted.
    for (int t = 0; t < 200; t++) begin
      v    = int'($urandom_range(0, 15));
      hold = int'($urandom_range(1, 6));
      bus.count_in = N'(v);
      for (int h = 0; h < hold; h++) begin
        bus.cmp_load = ($urandom_range(0, 7) == 0);
        bus.cmp_val  = N'($urandom_range(0, 15));
        bus.wrap_clr = ($urandom_range(0, 15) == 0);
        @(negedge clk);
      end
      $display("rand count_in=%0d hold=%0d count_q=%0d wrap_cnt=%0d", v, hold, bus.count_q, bus.wrap_cnt);
    end
    bus.cmp_load = 1'b0;
    bus.wrap_clr = 1'b0;
    repeat (10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
